// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 receive-only UART.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_e;

  localparam int DATA_BITS   = 8;
  localparam int SYNC_STAGES = 2;

  // Clock cycles per serial bit (integer division, truncating).
  function automatic int calc_clks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; resets to idle (1).
module uart_sync
  import uart_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw line in at the bottom of the chain.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Chain registers; reset to the idle-high level so no false start follows reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart.sv
// Receive-only 8N1 UART: mid-bit sampling, holds the last correctly framed byte.
module uart
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ   = 50000000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_FREQ, BAUD_RATE)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] Out
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   out_q, out_d;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uart_rx),
    .q     (rx_s)
  );

  // Frame FSM: start qualification at mid-start, data capture every bit, stop check.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    out_d     = out_q;
    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // A line back high at mid-start was a glitch, not a frame.
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == IDX_LAST) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            out_d   = shift_q;
            state_d = IDLE;
          end else begin
            // Framing error: drop the byte and wait out the low line.
            shift_d = '0;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counters, shift register and output hold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      out_q     <= out_d;
    end
  end

  assign Out = out_q;

endmodule

// File: tb/tb_uart.sv
// Bench for uart: serial driver, expected-byte model, per-cycle output compare.
`timescale 1ns/1ps
module tb_uart;

  localparam real BIT_NS = 8680.0;

  logic       clk;
  logic       rst_n;
  logic       uart_rx;
  logic [7:0] Out;

  int checks = 0;
  int errors = 0;

  // Model: the byte Out must show, and whether Out is settled (not inside
  // the stop-bit window where the DUT may legitimately switch).
  logic [7:0] exp_out;
  bit         meaningful;

  uart dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .uart_rx (uart_rx),
    .Out     (Out)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Continuous comparison against the model away from the active edge.
  always @(negedge clk) begin
    if (meaningful) begin
      checks++;
      if (Out !== exp_out) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t Out=%02h expected=%02h", $time, Out, exp_out);
      end
    end
  end

  task automatic check_lit(input string name, input logic [7:0] want);
    checks++;
    if (Out !== want) begin
      errors++;
      $display("FAIL %s Out=%02h expected=%02h", name, Out, want);
    end
  endtask

  // Drive one 8N1 frame with period scaled by skew; optional idle bits after.
  // The model takes the byte at the end of the stop bit if the stop bit is 1.
  task automatic send_frame(input logic [7:0] data, input bit stop_bit,
                            input real skew, input int idle_bits);
    real p;
    p = BIT_NS * skew;
    uart_rx = 1'b0;
    #(p);
    for (int i = 0; i < 8; i++) begin
      uart_rx = data[i];
      #(p);
    end
    meaningful = 1'b0;
    uart_rx = stop_bit;
    #(p);
    uart_rx = 1'b1;
    if (stop_bit) exp_out = data;
    meaningful = 1'b1;
    for (int i = 0; i < idle_bits; i++) #(p);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] rb;
    bit         rs;
    real        sk;
    rst_n      = 1'b0;
    uart_rx    = 1'b1;
    exp_out    = 8'h00;
    meaningful = 1'b1;
    #105;
    rst_n = 1'b1;
    #1000;
    check_lit("reset_idle", 8'h00);

    // Basic frames, checked 12 bit periods after start.
    send_frame(8'h5A, 1'b1, 1.0, 2); check_lit("rx_5A", 8'h5A);
    send_frame(8'hA3, 1'b1, 1.0, 2); check_lit("rx_A3", 8'hA3);
    send_frame(8'hB3, 1'b1, 1.0, 2); check_lit("rx_B3", 8'hB3);

    // Framing error keeps the previous byte.
    send_frame(8'h5A, 1'b1, 1.0, 1); check_lit("rx_5A_again", 8'h5A);
    send_frame(8'h3C, 1'b0, 1.0, 1); check_lit("frame_err_hold", 8'h5A);
    send_frame(8'hC3, 1'b1, 1.0, 1); check_lit("rx_C3", 8'hC3);

    // Start glitch shorter than half a bit.
    uart_rx = 1'b0;
    #2000;
    uart_rx = 1'b1;
    #(BIT_NS);
    check_lit("glitch_hold", 8'hC3);
    send_frame(8'h81, 1'b1, 1.0, 1); check_lit("rx_81", 8'h81);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, 1.0, 0); check_lit("b2b_00", 8'h00);
    send_frame(8'hFF, 1'b1, 1.0, 1); check_lit("b2b_FF", 8'hFF);

    // Reset in the middle of data bit 4 of 8'h77.
    begin
      logic [7:0] d77;
      d77 = 8'h77;
      uart_rx = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 4; i++) begin
        uart_rx = d77[i];
        #(BIT_NS);
      end
      uart_rx = d77[4];
      #(BIT_NS / 2.0);
      rst_n   = 1'b0;
      exp_out = 8'h00;
      #1;
      check_lit("reset_mid_frame", 8'h00);
      uart_rx = 1'b1;
      #1000;
      rst_n = 1'b1;
      #(BIT_NS * 2.0);
      check_lit("after_reset_idle", 8'h00);
    end
    send_frame(8'h12, 1'b1, 1.0, 1); check_lit("rx_12", 8'h12);

    // Baud skew.
    send_frame(8'hA5, 1'b1, 1.03, 1); check_lit("skew_plus", 8'hA5);
    send_frame(8'h5A, 1'b1, 1.0, 1);
    send_frame(8'hA5, 1'b1, 0.97, 1); check_lit("skew_minus", 8'hA5);

    // Random bytes, occasional framing errors, small skew.
    for (int n = 0; n < 4; n++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      sk = 0.98 + 0.001 * real'($urandom_range(0, 40));
      send_frame(rb, rs, sk, 1);
    end
    #1000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
